// File: rtl/key_loader_enc64.sv
// key_loader_enc64: serial 64-bit key loader with XOR checksum, zeroize and fail lockout
module key_loader_enc64 #(
   parameter int MAX_FAIL = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        zeroize_i,
   input  logic        key_bit_i,
   input  logic        key_vld_i,
   output logic        key_rdy_o,
   output logic [63:0] keyinput_o,
   output logic        key_ready_o,
   output logic        key_err_o,
   output logic        locked_out_o,
   output logic        busy_o
);
   localparam int FW = $clog2(MAX_FAIL + 1);
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, ACTIVE, ERROR, LOCKOUT} state_t;
   state_t state, nxt;
   logic [63:0] shadow;
   logic [7:0] csum;
   logic [6:0] cnt;
   logic [FW-1:0] fails, fails_inc;
   logic take, match;
   assign take = state == LOAD && key_vld_i && !zeroize_i;
   assign match = csum == (shadow[7:0] ^ shadow[15:8] ^ shadow[23:16] ^ shadow[31:24] ^
                           shadow[39:32] ^ shadow[47:40] ^ shadow[55:48] ^ shadow[63:56]);
   assign fails_inc = (fails == FW'(MAX_FAIL)) ? fails : fails + 1'b1;
   assign key_rdy_o = state == LOAD;
   assign busy_o = state == LOAD || state == CHECK;
   assign key_ready_o = state == ACTIVE;
   assign locked_out_o = state == LOCKOUT;
   // next state: lockout holds, then zeroize, then start, then data transfer
   always_comb begin
      nxt = state;
      if (state != LOCKOUT) begin
         if (zeroize_i) nxt = IDLE;
         else case (state)
            IDLE, ACTIVE, ERROR: if (start_i) nxt = LOAD;
            LOAD: if (key_vld_i && cnt == 7'd71) nxt = CHECK;
            CHECK: nxt = match ? ACTIVE : (fails_inc == FW'(MAX_FAIL) ? LOCKOUT : ERROR);
            default: nxt = state;
         endcase
      end
   end
   // state register plus key, checksum, counter and fail-count datapath
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         shadow <= '0;
         csum <= '0;
         cnt <= '0;
         fails <= '0;
         keyinput_o <= '0;
         key_err_o <= 1'b0;
      end else begin
         state <= nxt;
         keyinput_o <= (nxt == ACTIVE) ? (state == CHECK ? shadow : keyinput_o) : '0;
         if (state != LOCKOUT && zeroize_i) begin
            shadow <= '0;
            csum <= '0;
            cnt <= '0;
            key_err_o <= 1'b0;
         end else if (nxt == LOAD && state != LOAD) begin
            shadow <= '0;
            csum <= '0;
            cnt <= '0;
         end else if (take) begin
            if (cnt < 7'd64) shadow[cnt[5:0]] <= key_bit_i;
            else csum[cnt[2:0]] <= key_bit_i;
            cnt <= cnt + 7'd1;
         end else if (state == CHECK) begin
            key_err_o <= !match;
            fails <= match ? '0 : fails_inc;
         end
      end
   end
endmodule

// File: tb/tb_key_loader_enc64.sv
// tb_key_loader_enc64: randomized self-checking bench with a byte-XOR checksum model
module tb_key_loader_enc64;
   logic clk = 0, rst = 1, start = 0, zeroize = 0, key_bit = 0, key_vld = 0;
   logic key_rdy, key_ready, key_err, locked_out, busy;
   logic [63:0] keyinput;
   int compared = 0, mismatched = 0, mf = 0;

   key_loader_enc64 #(.MAX_FAIL(3)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .zeroize_i(zeroize),
      .key_bit_i(key_bit), .key_vld_i(key_vld), .key_rdy_o(key_rdy),
      .keyinput_o(keyinput), .key_ready_o(key_ready), .key_err_o(key_err),
      .locked_out_o(locked_out), .busy_o(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xsum(input logic [63:0] k);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 8; i++) s ^= 8'((k >> (8 * i)) & 64'hFF);
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      step();
      rst = 0;
      mf = 0;
   endtask

   task automatic do_start();
      start = 1;
      step();
      start = 0;
   endtask

   task automatic send(input logic [63:0] k, input logic [7:0] c, input int n, input bit rnd);
      logic [71:0] s;
      int i, g;
      s = {c, k};
      i = 0;
      g = 0;
      while (i < n && g < 1000) begin
         key_vld = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         key_bit = s[i];
         step();
         if (key_vld) i++;
         g++;
      end
      key_vld = 0;
   endtask

   task automatic test_reset();
      do_reset();
      compared++; if (keyinput !== 64'h0) begin mismatched++; $display("FAIL reset_key got %h want 0", keyinput); end
      compared++; if ({key_ready, key_err, locked_out, busy, key_rdy} !== 5'b0) begin mismatched++; $display("FAIL reset_flags got %b want 00000", {key_ready, key_err, locked_out, busy, key_rdy}); end
   endtask

   task automatic test_valid_load();
      logic [63:0] k = 64'h0123456789ABCDEF;
      do_start();
      compared++; if ({key_rdy, busy} !== 2'b11) begin mismatched++; $display("FAIL load_flags got %b want 11", {key_rdy, busy}); end
      send(k, xsum(k), 72, 0);
      compared++; if ({busy, key_ready, key_rdy} !== 3'b100) begin mismatched++; $display("FAIL check_cycle got %b want 100", {busy, key_ready, key_rdy}); end
      step();
      mf = 0;
      compared++; if (key_ready !== 1'b1) begin mismatched++; $display("FAIL latency_ready got %b want 1", key_ready); end
      compared++; if (keyinput !== k) begin mismatched++; $display("FAIL valid_key got %h want %h", keyinput, k); end
      compared++; if ({key_err, busy} !== 2'b00) begin mismatched++; $display("FAIL valid_flags got %b want 00", {key_err, busy}); end
   endtask

   task automatic test_bad_then_good();
      logic [63:0] k = 64'h0123456789ABCDEF;
      do_start();
      compared++; if (keyinput !== 64'h0) begin mismatched++; $display("FAIL start_clears got %h want 0", keyinput); end
      send(k, 8'h01, 72, 0);
      step();
      mf++;
      compared++; if ({key_err, key_ready, locked_out} !== 3'b100) begin mismatched++; $display("FAIL bad_flags got %b want 100", {key_err, key_ready, locked_out}); end
      compared++; if (keyinput !== 64'h0) begin mismatched++; $display("FAIL bad_key got %h want 0", keyinput); end
      do_start();
      send(k, xsum(k), 72, 0);
      step();
      mf = 0;
      compared++; if ({key_err, key_ready} !== 2'b01) begin mismatched++; $display("FAIL reload_flags got %b want 01", {key_err, key_ready}); end
      compared++; if (keyinput !== k) begin mismatched++; $display("FAIL reload_key got %h want %h", keyinput, k); end
   endtask

   task automatic test_lockout();
      logic [63:0] k;
      for (int t = 0; t < 3; t++) begin
         k = {$urandom, $urandom};
         do_start();
         send(k, ~xsum(k), 72, 0);
         step();
         mf++;
         compared++; if (locked_out !== (mf == 3)) begin mismatched++; $display("FAIL lock_step%0d got %b want %b", t, locked_out, mf == 3); end
         compared++; if (key_err !== 1'b1) begin mismatched++; $display("FAIL lock_err%0d got %b want 1", t, key_err); end
         if (t == 0) begin
            zeroize = 1;
            step();
            zeroize = 0;
            compared++; if ({key_err, busy, key_ready} !== 3'b000) begin mismatched++; $display("FAIL zero_err got %b want 000", {key_err, busy, key_ready}); end
         end
      end
      start = 1;
      zeroize = 1;
      key_vld = 1;
      step();
      step();
      start = 0;
      zeroize = 0;
      key_vld = 0;
      compared++; if ({locked_out, key_rdy, busy, key_ready} !== 4'b1000) begin mismatched++; $display("FAIL lock_hold got %b want 1000", {locked_out, key_rdy, busy, key_ready}); end
      compared++; if (keyinput !== 64'h0) begin mismatched++; $display("FAIL lock_key got %h want 0", keyinput); end
      do_reset();
      compared++; if ({locked_out, key_err} !== 2'b00) begin mismatched++; $display("FAIL unlock got %b want 00", {locked_out, key_err}); end
   endtask

   task automatic test_stall();
      logic [63:0] k = 64'hFFFFFFFF00000000;
      do_start();
      send(k, 8'h00, 72, 1);
      compared++; if ({busy, key_ready} !== 2'b10) begin mismatched++; $display("FAIL stall_check got %b want 10", {busy, key_ready}); end
      step();
      mf = 0;
      compared++; if (keyinput !== k) begin mismatched++; $display("FAIL stall_key got %h want %h", keyinput, k); end
      compared++; if ({key_ready, key_err} !== 2'b10) begin mismatched++; $display("FAIL stall_flags got %b want 10", {key_ready, key_err}); end
   endtask

   task automatic test_zeroize();
      logic [63:0] k = {$urandom, $urandom};
      do_start();
      send(k, xsum(k), 40, 0);
      zeroize = 1;
      step();
      zeroize = 0;
      compared++; if ({busy, key_rdy, key_ready} !== 3'b000) begin mismatched++; $display("FAIL zero_load got %b want 000", {busy, key_rdy, key_ready}); end
      key_vld = 1;
      repeat (4) step();
      key_vld = 0;
      compared++; if ({busy, key_rdy} !== 2'b00) begin mismatched++; $display("FAIL zero_idle got %b want 00", {busy, key_rdy}); end
      do_start();
      send(k, xsum(k), 72, 0);
      step();
      mf = 0;
      compared++; if (keyinput !== k) begin mismatched++; $display("FAIL zero_reload got %h want %h", keyinput, k); end
      zeroize = 1;
      step();
      zeroize = 0;
      compared++; if ({key_ready, busy} !== 2'b00) begin mismatched++; $display("FAIL zero_active got %b want 00", {key_ready, busy}); end
      compared++; if (keyinput !== 64'h0) begin mismatched++; $display("FAIL zero_key got %h want 0", keyinput); end
   endtask

   task automatic test_rst_mid_load();
      logic [63:0] k1 = {$urandom, $urandom}, k2 = {$urandom, $urandom};
      do_start();
      send(k1, xsum(k1), 20, 0);
      do_reset();
      key_vld = 1;
      key_bit = 1;
      repeat (3) step();
      key_vld = 0;
      compared++; if ({busy, key_rdy, key_ready} !== 3'b000) begin mismatched++; $display("FAIL rst_idle got %b want 000", {busy, key_rdy, key_ready}); end
      do_start();
      send(k2, xsum(k2), 72, 0);
      step();
      compared++; if (keyinput !== k2) begin mismatched++; $display("FAIL rst_reload got %h want %h", keyinput, k2); end
      compared++; if (key_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready got %b want 1", key_ready); end
   endtask

   task automatic test_random();
      logic [63:0] k, exp_key;
      logic [7:0] c;
      bit ok;
      for (int t = 0; t < 10; t++) begin
         if (mf == 3) do_reset();
         k = {$urandom, $urandom};
         ok = 1'($urandom_range(0, 1));
         c = ok ? xsum(k) : xsum(k) ^ 8'(1 << $urandom_range(0, 7));
         do_start();
         compared++; if ({keyinput, key_rdy} !== {64'h0, 1'b1}) begin mismatched++; $display("FAIL rnd_start%0d got %h/%b want 0/1", t, keyinput, key_rdy); end
         send(k, c, 72, 1);
         step();
         mf = ok ? 0 : (mf < 3 ? mf + 1 : mf);
         exp_key = ok ? k : 64'h0;
         compared++; if (keyinput !== exp_key) begin mismatched++; $display("FAIL rnd_key%0d got %h want %h", t, keyinput, exp_key); end
         compared++; if ({key_ready, key_err, locked_out} !== {ok, !ok, mf == 3}) begin mismatched++; $display("FAIL rnd_flags%0d got %b want %b", t, {key_ready, key_err, locked_out}, {ok, !ok, mf == 3}); end
      end
   endtask

   initial begin
      test_reset();
      test_valid_load();
      test_bad_then_good();
      test_lockout();
      test_stall();
      test_zeroize();
      test_rst_mid_load();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
